// File: rtl/apb_init_sequencer_if.sv
// APB bus bundle shared by the bridge side and the peripheral side of the init sequencer.
// A module that issues transfers connects through the master modport; one that answers them uses the slave modport.
interface apb_init_sequencer_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_init_sequencer.sv
// Boot-time APB write sequencer: replays a ROM table of {paddr, pwdata} writes after reset,
// then hands the peripheral bus to the upstream bridge as a combinational pass-through.
module apb_init_sequencer #(
  parameter int  NUM_ENTRIES = 16,
  parameter int  TIMEOUT     = 255,
  localparam int IW          = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
  localparam int CW          = $clog2(TIMEOUT + 1)
) (
  input  logic                 HCLK,
  input  logic                 RESETn,
  output logic [IW-1:0]        rom_addr,
  input  logic [47:0]          rom_data,
  input  logic                 start,
  apb_init_sequencer_if.slave  up,
  apb_init_sequencer_if.master m,
  output logic                 init_busy,
  output logic                 init_done,
  output logic                 init_err,
  output logic [IW-1:0]        err_idx
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [IW-1:0] r_idx;
  logic [15:0]   r_paddr;
  logic [31:0]   r_pwdata;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic [IW-1:0] r_err_idx;
  logic          r_gap;

  logic          w_end_marker;
  logic          w_timeout;
  logic          w_exit;
  logic          w_fail;
  logic          w_last;
  logic          w_start_ok;
  logic          w_fwd;
  logic          w_seq_xfer;

  assign w_end_marker = (rom_data[47:32] == 16'hFFFF);
  assign w_timeout    = !m.pready && (r_cnt == CW'(TIMEOUT - 1));
  assign w_exit       = (r_state == S_ACCESS) && (m.pready || w_timeout);
  assign w_fail       = w_exit && (w_timeout || m.pslverr);
  assign w_last       = (r_idx == IW'(NUM_ENTRIES - 1));
  // A restart is only taken when no bridge transfer is in flight, so ownership never flips mid-transfer.
  assign w_start_ok   = (r_state == S_DONE) && start && !up.psel;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: w_next_state = w_end_marker ? S_DONE : S_SETUP;
      S_SETUP:  w_next_state = S_ACCESS;
      S_ACCESS: begin
        if (w_exit) begin
          w_next_state = w_last ? S_DONE : S_FETCH;
        end
      end
      S_DONE:   if (w_start_ok) w_next_state = S_FETCH;
      default:  w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge HCLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state   <= S_FETCH;
      r_idx     <= '0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
      r_gap     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_DECODE: begin
          if (!w_end_marker) begin
            r_paddr  <= rom_data[47:32];
            r_pwdata <= rom_data[31:0];
          end
        end
        S_ACCESS: begin
          if (w_exit) begin
            r_cnt <= '0;
            if (!w_last) r_idx <= r_idx + IW'(1);
            // Leaving straight from ACCESS into DONE: hold the bus idle for one cycle before forwarding.
            r_gap <= w_last;
            if (w_fail) begin
              r_err <= 1'b1;
              if (!r_err) r_err_idx <= r_idx;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_gap <= 1'b0;
          if (w_start_ok) begin
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_err_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_fwd      = (r_state == S_DONE) && !r_gap;
  assign w_seq_xfer = (r_state == S_SETUP) || (r_state == S_ACCESS);

  assign m.psel     = w_fwd ? up.psel    : w_seq_xfer;
  assign m.penable  = w_fwd ? up.penable : (r_state == S_ACCESS);
  assign m.pwrite   = w_fwd ? up.pwrite  : w_seq_xfer;
  assign m.paddr    = w_fwd ? up.paddr   : r_paddr;
  assign m.pwdata   = w_fwd ? up.pwdata  : r_pwdata;

  // Until the bus is handed over the bridge sees a stalled access phase with a quiet response.
  assign up.prdata  = w_fwd ? m.prdata  : 32'h0;
  assign up.pready  = w_fwd ? m.pready  : 1'b0;
  assign up.pslverr = w_fwd ? m.pslverr : 1'b0;

  assign rom_addr   = r_idx;
  assign init_busy  = (r_state != S_DONE);
  assign init_done  = (r_state == S_DONE);
  assign init_err   = r_err;
  assign err_idx    = r_err_idx;

endmodule
